cpu_port_stimulator: RTL and testbench

Synthesizable stimulus/response port for the CME341 microprocessor. It drives the processor's 4-bit `i_pins` from a host-loaded stimulus FIFO, holding each nibble for a programmable number of cycles. It also watches the processor's 4-bit `o_reg` and logs every change, with an 8-bit timestamp, into a capture FIFO the host drains. It sits between a host/bench controller and the microprocessor and replaces the free-running counter stimulus with scripted, observable I/O.

---
 rtl/cpu_port_pkg.sv | 14 +
 rtl/cpu_port_stimulator_sync_fifo.sv | 74 +++++++
 rtl/cpu_port_stimulator.sv | 151 +++++++++++++++
 tb/tb_cpu_port_stimulator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_port_pkg.sv
// Shared types and widths for the CME341 stimulus/response port.
// The stimulus FSM enum and the capture-entry layout live here.
package cpu_port_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } stim_state_e;

   localparam int NIB_W = 4;
   localparam int TS_W  = 8;
   localparam int CAP_W = TS_W + NIB_W;

endpackage

// File: rtl/cpu_port_stimulator_sync_fifo.sv
// Small first-word-fall-through FIFO with full/empty flags.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == {(AW+1){1'b0}});
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign head      = mem_q[rd_ptr_q];

   // Next pointer, count and storage contents
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; stale contents are harmless since empty gates the head
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/cpu_port_stimulator.sv
// Scripted I/O port for the CME341 processor: replays host nibbles on i_pins
// with a fixed hold time and logs timestamped o_reg changes for the host.
module cpu_port_stimulator
   import cpu_port_pkg::*;
#(
   parameter int HOLD_CYCLES = 16,
   parameter int DEPTH       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NIB_W-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [NIB_W-1:0] i_pins,
   input  logic [NIB_W-1:0] o_reg,
   output logic [CAP_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             busy
);

   localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

   stim_state_e      state_q, state_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic [NIB_W-1:0] i_pins_q, i_pins_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic [NIB_W-1:0] o_reg_q, o_reg_d;
   logic             overflow_q, overflow_d;

   logic             stim_push_s, stim_pop_s, stim_full_s, stim_empty_s;
   logic [NIB_W-1:0] stim_head_s;
   logic             cap_push_s, cap_full_s, cap_empty_s;
   logic [CAP_W-1:0] cap_head_s;

   assign stim_push_s = in_valid & ~stim_full_s;
   assign cap_push_s  = (o_reg != o_reg_q);

   sync_fifo #(.WIDTH(NIB_W), .DEPTH(DEPTH)) u_stim_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (stim_push_s),
      .push_data (in_data),
      .pop       (stim_pop_s),
      .head      (stim_head_s),
      .full      (stim_full_s),
      .empty     (stim_empty_s)
   );

   sync_fifo #(.WIDTH(CAP_W), .DEPTH(DEPTH)) u_cap_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cap_push_s),
      .push_data ({ts_q, o_reg}),
      .pop       (out_ready),
      .head      (cap_head_s),
      .full      (cap_full_s),
      .empty     (cap_empty_s)
   );

   // Stimulus FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Stimulus FSM next state: leave HOLD only when the hold expires with nothing queued
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!stim_empty_s) state_d = HOLD;
            else               state_d = IDLE;
         end
         HOLD: begin
            if ((hold_cnt_q == 8'd0) && stim_empty_s) state_d = IDLE;
            else                                      state_d = HOLD;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stimulus FSM outputs: pop, pin drive and hold counter
   always_comb begin
      stim_pop_s = 1'b0;
      i_pins_d   = i_pins_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (!stim_empty_s) begin
               stim_pop_s = 1'b1;
               i_pins_d   = stim_head_s;
               hold_cnt_d = HOLD_RELOAD;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         HOLD: begin
            if (hold_cnt_q != 8'd0) begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end else if (!stim_empty_s) begin
               stim_pop_s = 1'b1;
               i_pins_d   = stim_head_s;
               hold_cnt_d = HOLD_RELOAD;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         default: begin
            stim_pop_s = 1'b0;
            hold_cnt_d = 8'd0;
         end
      endcase
   end

   // Timestamp, change-detect sample and sticky drop flag
   always_comb begin
      ts_d       = ts_q + 8'd1;
      o_reg_d    = o_reg;
      overflow_d = overflow_q | (cap_push_s & cap_full_s & ~out_ready);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_q <= 8'd0;
         i_pins_q   <= {NIB_W{1'b0}};
         ts_q       <= {TS_W{1'b0}};
         o_reg_q    <= {NIB_W{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         i_pins_q   <= i_pins_d;
         ts_q       <= ts_d;
         o_reg_q    <= o_reg_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = ~stim_full_s;
   assign i_pins    = i_pins_q;
   assign out_valid = ~cap_empty_s;
   assign out_data  = cap_empty_s ? {CAP_W{1'b0}} : cap_head_s;
   assign overflow  = overflow_q;
   assign busy      = (state_q == HOLD) | ~stim_empty_s;

endmodule

// File: tb/tb_cpu_port_stimulator.sv
// Self-checking bench: a queue-based model of the port is compared every cycle,
// with directed scenarios pinning literal values, then randomized traffic.
module tb_cpu_port_stimulator;

   localparam int HOLD  = 16;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  in_data = 4'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  i_pins;
   logic [3:0]  o_reg = 4'h0;
   logic [11:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overflow;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit          m_live = 1'b0;
   logic [3:0]  sq[$];
   logic [11:0] cq[$];
   logic [3:0]  m_pins;
   bit          m_holding;
   int          m_age;
   logic [3:0]  m_prev;
   int          m_ts;
   bit          m_ovf;

   cpu_port_stimulator #(.HOLD_CYCLES(HOLD), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .i_pins    (i_pins),
      .o_reg     (o_reg),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic wait_ts(input int t);
      for (int i = 0; i < 300 && m_ts != t; i++) step();
      check("ts_wait_bound", 12'(m_ts), 12'(t));
   endtask

   // Reference model: each nibble is shown for HOLD cycles, queues hold the FIFOs
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_live    = 1'b1;
            sq.delete();
            cq.delete();
            m_pins    = 4'h0;
            m_holding = 1'b0;
            m_age     = 0;
            m_prev    = 4'h0;
            m_ts      = 0;
            m_ovf     = 1'b0;
         end else if (m_live) begin
            int  pre_sz;
            bit  take, cpop, cacc;
            pre_sz = sq.size();
            take   = 1'b0;
            if (m_holding) begin
               m_age++;
               if (m_age == HOLD) begin
                  if (pre_sz > 0) take = 1'b1;
                  else            m_holding = 1'b0;
               end
            end else if (pre_sz > 0) begin
               take = 1'b1;
            end
            if (take) begin
               m_pins    = sq.pop_front();
               m_holding = 1'b1;
               m_age     = 0;
            end
            if (in_valid && pre_sz < DEPTH) sq.push_back(in_data);

            cpop = out_ready && (cq.size() > 0);
            cacc = 1'b0;
            if (o_reg != m_prev) begin
               if (cq.size() < DEPTH || cpop) cacc = 1'b1;
               else                           m_ovf = 1'b1;
            end
            if (cpop) void'(cq.pop_front());
            if (cacc) cq.push_back({8'(m_ts), o_reg});
            m_prev = o_reg;
            m_ts   = (m_ts + 1) % 256;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            check("i_pins", 12'(i_pins), 12'(m_pins));
            check("in_ready", 12'(in_ready), 12'(sq.size() < DEPTH));
            check("busy", 12'(busy), 12'(m_holding || sq.size() > 0));
            check("out_valid", 12'(out_valid), 12'(cq.size() > 0));
            check("out_data", out_data, (cq.size() > 0) ? cq[0] : 12'h000);
            check("overflow", 12'(overflow), 12'(m_ovf));
         end
      end
   end

   initial begin
      step();
      step();
      reset = 1'b0;

      // reset idle for 50 cycles
      for (int i = 0; i < 50; i++) step();
      check("idle_pins", 12'(i_pins), 12'h000);
      check("idle_valid", 12'(out_valid), 12'h000);
      check("idle_busy", 12'(busy), 12'h000);
      check("idle_ovf", 12'(overflow), 12'h000);

      // stimulus sequence 3, A, F
      do_reset();
      in_valid = 1'b1; in_data = 4'h3;
      step();
      in_data = 4'hA;
      step();
      check("seq_e1", 12'(i_pins), 12'h003);
      in_data = 4'hF;
      step();
      in_valid = 1'b0;
      for (int e = 2; e <= 50; e++) begin
         if (e == 16) check("seq_e16", 12'(i_pins), 12'h003);
         if (e == 17) check("seq_e17", 12'(i_pins), 12'h00A);
         if (e == 32) check("seq_e32", 12'(i_pins), 12'h00A);
         if (e == 33) check("seq_e33", 12'(i_pins), 12'h00F);
         if (e == 48) check("seq_busy48", 12'(busy), 12'h001);
         if (e == 49) check("seq_busy49", 12'(busy), 12'h000);
         if (e == 50) check("seq_hold_f", 12'(i_pins), 12'h00F);
         step();
      end

      // capture timestamps including wrap
      do_reset();
      wait_ts(8'h21);
      o_reg = 4'h5;
      step();
      check("cap_215", out_data, 12'h215);
      wait_ts(8'hFF);
      o_reg = 4'h9;
      step();
      o_reg = 4'h4;
      step();
      check("cap_head", out_data, 12'h215);
      out_ready = 1'b1;
      step();
      check("cap_ff9", out_data, 12'hFF9);
      step();
      check("cap_004", out_data, 12'h004);
      out_ready = 1'b0;
      step();

      // capture overflow, then the same with a rescuing pop
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         o_reg = 4'(i);
         step();
      end
      check("ovf_set", 12'(overflow), 12'h001);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      out_ready = 1'b0;
      check("ovf_drained", 12'(out_valid), 12'h000);
      check("ovf_sticky", 12'(overflow), 12'h001);
      do_reset();
      o_reg = 4'h0;
      step();
      for (int i = 1; i <= 4; i++) begin
         o_reg = 4'(i);
         step();
      end
      o_reg = 4'h5; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("ovf_rescued", 12'(overflow), 12'h000);
      o_reg = 4'h0;

      // stimulus FIFO full while holding
      do_reset();
      in_valid = 1'b1; in_data = 4'h1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      for (int i = 2; i <= 5; i++) begin
         in_valid = 1'b1; in_data = 4'(i);
         step();
      end
      check("full_ready0", 12'(in_ready), 12'h000);
      in_data = 4'h6;
      step();
      in_valid = 1'b0;
      check("full_still0", 12'(in_ready), 12'h000);
      for (int i = 0; i < 40 && i_pins != 4'h2; i++) step();
      check("full_next_nib", 12'(i_pins), 12'h002);
      check("full_ready1", 12'(in_ready), 12'h001);

      // reset mid-operation
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 4'(7 + i);
         o_reg = 4'(1 + i);
         step();
      end
      in_valid = 1'b0;
      do_reset();
      check("rst_pins", 12'(i_pins), 12'h000);
      check("rst_valid", 12'(out_valid), 12'h000);
      check("rst_ready", 12'(in_ready), 12'h001);
      check("rst_busy", 12'(busy), 12'h000);
      step();
      check("rst_ts0", out_data, 12'h003);
      in_valid = 1'b1; in_data = 4'hC;
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      step();
      check("pulse_ignored", 12'(i_pins), 12'h00C);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(0, 2) == 0);
         in_data   = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 2) == 0) o_reg = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) do_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
